regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file; successor to the single-write GPR file.
//  - NUM_RD combinational read ports and two prioritised synchronous write ports.
//  - Per-register busy scoreboard for multicycle producers (loads, mult/div).
//  - Sits between decode (reads, busy checks) and writeback (writes) in the MIPS core.
// PARAMETERS
//  DATA_W    32  register width in bits
//  DEPTH     32  number of registers; power of two, >= 2
//  ADDR_W    $clog2(DEPTH)  register address width (derived; do not override)
//  NUM_RD    2   number of read ports, 1..4
//  ZERO_REG  1   1: register 0 reads as 0, writes and busy-sets to it are ignored
//  DBG_REG   2   index of register driven on dbg_data_o (default is $v0)
// PORTS
//  clk            in   1              rising-edge clock
//  reset_i        in   1              synchronous reset, active-high
//  rd_addr_i      in   NUM_RD*ADDR_W  read addresses; port k = bits [k*ADDR_W +: ADDR_W]
//  rd_data_o      out  NUM_RD*DATA_W  read data; port k = bits [k*DATA_W +: DATA_W]
//  rd_busy_o      out  NUM_RD         busy bit of register addressed by read port k
//  wr0_en_i       in   1              write port 0 enable
//  wr0_addr_i     in   ADDR_W         write port 0 address
//  wr0_data_i     in   DATA_W         write port 0 data
//  wr1_en_i       in   1              write port 1 enable (priority port)
//  wr1_addr_i     in   ADDR_W         write port 1 address
//  wr1_data_i     in   DATA_W         write port 1 data
//  busy_set_i     in   1              mark busy_set_addr_i pending
//  busy_set_addr_i in  ADDR_W         register to mark pending
//  dbg_data_o     out  DATA_W         current value of register DBG_REG
// BEHAVIOUR
//  - Reset: clk and reset_i (synchronous, active-high), one clock. At the
//    first rising edge with reset_i=1, all registers and busy bits clear to 0.
//    Reset overrides all writes and busy-sets in that cycle. After reset:
//    rd_data_o=0, rd_busy_o=0, dbg_data_o=0.
//  - Reads are combinational from the register array, with zero latency.
//  - Writes commit at the rising edge when the enable is 1. Write data is
//    visible on reads the next cycle; see also REGFILE_BYPASS_EN.
//  - Both write ports target the same address in one cycle: the port 1 value
//    is stored and the port 0 value is dropped.
//  - ZERO_REG=1: reads of address 0 return 0. Writes and busy_set to address 0
//    are discarded. rd_busy_o is never 1 for address 0.
//  - Scoreboard: busy_set_i=1 sets busy[addr] at the edge.
//    Any committed write to addr, from either port, clears busy[addr] at the edge.
//    If a busy-set and a write hit the same address in one cycle, the set wins and busy stays 1.
//  - rd_busy_o[k] = busy[rd_addr_i[k]]. The output is combinational from the
//    registered busy bits.
//  - dbg_data_o follows the same read rules, including the bypass rule, for DBG_REG.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: write-first forwarding.
//    - A read whose address matches an enabled write in the same cycle returns
//      the write data. Port 1 has priority over port 0.
//    - The matching rd_busy_o is forced to 0 unless a busy_set to that address
//      occurs in the same cycle.
//    - The ZERO_REG rule still applies.
//  REGFILE_BYPASS_EN undefined: read-old. Same-cycle reads return the
//    pre-edge value. Busy reports registered state only.
// TESTING
//  1. Write R5=0xDEADBEEF on wr0; next cycle read R5 on all ports -> 0xDEADBEEF, busy=0.
//  2. Same cycle: wr0 R7=0x11, wr1 R7=0x22 -> R7 reads 0x22 next cycle.
//  3. Write R0=0xFFFFFFFF with busy_set R0 -> R0 reads 0 and busy=0 (ZERO_REG=1).
//  4. busy_set R9; next cycle rd_busy=1. Write R9=0x5 with busy_set R9 in the same
//     cycle -> busy stays 1. Write R9 alone -> busy 0 and R9=0x5.
//  5. Bypass on: wr1 R3=0xA5 while reading R3 -> 0xA5 in the same cycle.
//     Bypass off -> old value 0, then 0xA5 the next cycle.
//  6. Load R2=0x1234 and R31 busy, then assert reset_i together with a write
//     R4=0x9 -> all reads 0, all busy 0, dbg_data_o=0.

Source files
------------

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Parametrised multi-port register file with a per-register busy scoreboard.
//   NUM_RD combinational read ports, two prioritised synchronous write ports
//   (port 1 wins on an address collision) and a busy bit per register that is
//   set by busy_set_i and cleared by any committed write to that register.
//
// Optional feature macro:
//   REGFILE_BYPASS_EN  defined   -> write-first forwarding on reads, busy and dbg
//                      undefined -> read-old (registered state only)
//
// Ports:
//   clk              rising-edge clock
//   reset_i          synchronous active-high reset (clears registers and busy)
//   rd_addr_i        NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data_o        NUM_RD packed read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy_o        busy bit of the register addressed by each read port
//   wr0_en_i/addr/data  write port 0
//   wr1_en_i/addr/data  write port 1 (priority)
//   busy_set_i       mark busy_set_addr_i pending
//   busy_set_addr_i  register to mark pending
//   dbg_data_o       current value of register DBG_REG (same read rules)
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned DBG_REG  = 2
) (
    input  logic                       clk,
    input  logic                       reset_i,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]          rd_busy_o,
    input  logic                       wr0_en_i,
    input  logic [ADDR_W-1:0]          wr0_addr_i,
    input  logic [DATA_W-1:0]          wr0_data_i,
    input  logic                       wr1_en_i,
    input  logic [ADDR_W-1:0]          wr1_addr_i,
    input  logic [DATA_W-1:0]          wr1_data_i,
    input  logic                       busy_set_i,
    input  logic [ADDR_W-1:0]          busy_set_addr_i,
    output logic [DATA_W-1:0]          dbg_data_o
);

    localparam logic [ADDR_W-1:0] DBG_ADDR = ADDR_W'(DBG_REG);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_d;

    logic w_wr0_commit;
    logic w_wr1_commit;
    logic w_bset_commit;

    // Accesses to register 0 are dropped entirely when it is hard-wired to zero.
    assign w_wr0_commit  = wr0_en_i   && !((ZERO_REG != 0) && (wr0_addr_i == '0));
    assign w_wr1_commit  = wr1_en_i   && !((ZERO_REG != 0) && (wr1_addr_i == '0));
    assign w_bset_commit = busy_set_i && !((ZERO_REG != 0) && (busy_set_addr_i == '0));

    // Busy next state: writes clear, a same-cycle set overrides the clear.
    always_comb begin
        w_busy_d = r_busy;
        if (w_wr0_commit) begin
            w_busy_d[wr0_addr_i] = 1'b0;
        end
        if (w_wr1_commit) begin
            w_busy_d[wr1_addr_i] = 1'b0;
        end
        if (w_bset_commit) begin
            w_busy_d[busy_set_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_regs <= '{default: '0};
            r_busy <= '0;
        end else begin
            if (w_wr0_commit) begin
                r_regs[wr0_addr_i] <= wr0_data_i;
            end
            // Port 1 is assigned last so it wins an address collision.
            if (w_wr1_commit) begin
                r_regs[wr1_addr_i] <= wr1_data_i;
            end
            r_busy <= w_busy_d;
        end
    end

    // Read path: index NUM_RD of the loop is the debug port.
    always_comb begin
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;

        rd_data_o  = '0;
        rd_busy_o  = '0;
        dbg_data_o = '0;
        w_addr     = '0;
        w_data     = '0;
        w_busy     = 1'b0;

        for (int unsigned k = 0; k <= NUM_RD; k++) begin
            if (k < NUM_RD) begin
                w_addr = rd_addr_i[k*ADDR_W +: ADDR_W];
            end else begin
                w_addr = DBG_ADDR;
            end

            w_data = r_regs[w_addr];
            w_busy = r_busy[w_addr];

`ifdef REGFILE_BYPASS_EN
            // Forward only writes that will actually commit (not under reset).
            if (!reset_i && w_wr1_commit && (wr1_addr_i == w_addr)) begin
                w_data = wr1_data_i;
                w_busy = w_bset_commit && (busy_set_addr_i == w_addr);
            end else if (!reset_i && w_wr0_commit && (wr0_addr_i == w_addr)) begin
                w_data = wr0_data_i;
                w_busy = w_bset_commit && (busy_set_addr_i == w_addr);
            end
`endif

            if ((ZERO_REG != 0) && (w_addr == '0)) begin
                w_data = '0;
                w_busy = 1'b0;
            end

            if (k < NUM_RD) begin
                rd_data_o[k*DATA_W +: DATA_W] = w_data;
                rd_busy_o[k]                  = w_busy;
            end else begin
                dbg_data_o = w_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset_i;
    logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
    logic [NUM_RD*DATA_W-1:0] rd_data_o;
    logic [NUM_RD-1:0]        rd_busy_o;
    logic                     wr0_en_i;
    logic [ADDR_W-1:0]        wr0_addr_i;
    logic [DATA_W-1:0]        wr0_data_i;
    logic                     wr1_en_i;
    logic [ADDR_W-1:0]        wr1_addr_i;
    logic [DATA_W-1:0]        wr1_data_i;
    logic                     busy_set_i;
    logic [ADDR_W-1:0]        busy_set_addr_i;
    logic [DATA_W-1:0]        dbg_data_o;

    regfile_mp dut (
        .clk             (clk),
        .reset_i         (reset_i),
        .rd_addr_i       (rd_addr_i),
        .rd_data_o       (rd_data_o),
        .rd_busy_o       (rd_busy_o),
        .wr0_en_i        (wr0_en_i),
        .wr0_addr_i      (wr0_addr_i),
        .wr0_data_i      (wr0_data_i),
        .wr1_en_i        (wr1_en_i),
        .wr1_addr_i      (wr1_addr_i),
        .wr1_data_i      (wr1_data_i),
        .busy_set_i      (busy_set_i),
        .busy_set_addr_i (busy_set_addr_i),
        .dbg_data_o      (dbg_data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  busy;
        logic [31:0] dbg;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [1:0] busy, input logic [31:0] dbg);
        exp_t e;
        e.tag  = tag;
        e.d0   = d0;
        e.d1   = d1;
        e.busy = busy;
        e.dbg  = dbg;
        q_exp.push_back(e);
    endtask

    // Let combinational outputs settle, then compare against the oldest expectation.
    task automatic sample();
        exp_t e;
        #2;
        if (q_exp.size() == 0) begin
            check_eq("queue_empty", 32'd1, 32'd0);
        end else begin
            e = q_exp.pop_front();
            check_eq({e.tag, ".d0"},   rd_data_o[31:0],  e.d0);
            check_eq({e.tag, ".d1"},   rd_data_o[63:32], e.d1);
            check_eq({e.tag, ".busy"}, {30'd0, rd_busy_o}, {30'd0, e.busy});
            check_eq({e.tag, ".dbg"},  dbg_data_o,       e.dbg);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_en_i        = 1'b0;
        wr0_addr_i      = '0;
        wr0_data_i      = '0;
        wr1_en_i        = 1'b0;
        wr1_addr_i      = '0;
        wr1_data_i      = '0;
        busy_set_i      = 1'b0;
        busy_set_addr_i = '0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr_i = {a1, a0};
    endtask

    task automatic wr0(input logic [4:0] a, input logic [31:0] d);
        wr0_en_i   = 1'b1;
        wr0_addr_i = a;
        wr0_data_i = d;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [31:0] d);
        wr1_en_i   = 1'b1;
        wr1_addr_i = a;
        wr1_data_i = d;
    endtask

    task automatic bset(input logic [4:0] a);
        busy_set_i      = 1'b1;
        busy_set_addr_i = a;
    endtask

    initial begin
        idle();
        set_rd(5'd1, 5'd31);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;

        // Reset state
        push_exp("reset", 32'h0, 32'h0, 2'b00, 32'h0);
        sample();

        // Write R5 on port 0
        set_rd(5'd5, 5'd5);
        wr0(5'd5, 32'hDEADBEEF);
        push_exp("r5_same", BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0, 2'b00, 32'h0);
        sample();
        tick();
        idle();
        push_exp("r5_next", 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0);
        sample();

        // Both ports write R7: port 1 wins
        set_rd(5'd7, 5'd7);
        wr0(5'd7, 32'h11);
        wr1(5'd7, 32'h22);
        push_exp("r7_same", BYP ? 32'h22 : 32'h0, BYP ? 32'h22 : 32'h0, 2'b00, 32'h0);
        sample();
        tick();
        idle();
        push_exp("r7_prio", 32'h22, 32'h22, 2'b00, 32'h0);
        sample();

        // Register 0 ignores writes and busy-sets
        set_rd(5'd0, 5'd0);
        wr0(5'd0, 32'hFFFFFFFF);
        wr1(5'd0, 32'hFFFFFFFF);
        bset(5'd0);
        push_exp("r0_same", 32'h0, 32'h0, 2'b00, 32'h0);
        sample();
        tick();
        idle();
        push_exp("r0_next", 32'h0, 32'h0, 2'b00, 32'h0);
        sample();

        // Scoreboard on R9
        set_rd(5'd9, 5'd9);
        bset(5'd9);
        push_exp("r9_set_same", 32'h0, 32'h0, 2'b00, 32'h0);
        sample();
        tick();
        idle();
        push_exp("r9_busy", 32'h0, 32'h0, 2'b11, 32'h0);
        sample();
        wr0(5'd9, 32'h5);
        bset(5'd9);
        push_exp("r9_setwr_same", BYP ? 32'h5 : 32'h0, BYP ? 32'h5 : 32'h0, 2'b11, 32'h0);
        sample();
        tick();
        idle();
        push_exp("r9_set_wins", 32'h5, 32'h5, 2'b11, 32'h0);
        sample();
        wr1(5'd9, 32'h5);
        push_exp("r9_clr_same", 32'h5, 32'h5, BYP ? 2'b00 : 2'b11, 32'h0);
        sample();
        tick();
        idle();
        push_exp("r9_clr", 32'h5, 32'h5, 2'b00, 32'h0);
        sample();
        set_rd(5'd9, 5'd5);
        push_exp("mixed_rd", 32'h5, 32'hDEADBEEF, 2'b00, 32'h0);
        sample();

        // Independent writes on both ports
        set_rd(5'd10, 5'd11);
        wr0(5'd10, 32'h0000AAAA);
        wr1(5'd11, 32'h0000BBBB);
        tick();
        idle();
        push_exp("dual_wr", 32'h0000AAAA, 32'h0000BBBB, 2'b00, 32'h0);
        sample();

        // Port 1 forwarding / read-old on R3
        set_rd(5'd7, 5'd3);
        wr1(5'd3, 32'hA5);
        push_exp("r3_same", 32'h22, BYP ? 32'hA5 : 32'h0, 2'b00, 32'h0);
        sample();
        tick();
        idle();
        push_exp("r3_next", 32'h22, 32'hA5, 2'b00, 32'h0);
        sample();

        // Debug port tracks R2
        set_rd(5'd2, 5'd3);
        wr0(5'd2, 32'h1234);
        push_exp("dbg_same", BYP ? 32'h1234 : 32'h0, 32'hA5, 2'b00, BYP ? 32'h1234 : 32'h0);
        sample();
        tick();
        idle();
        push_exp("dbg_next", 32'h1234, 32'hA5, 2'b00, 32'h1234);
        sample();

        // R31 busy, then reset together with a write
        bset(5'd31);
        tick();
        idle();
        set_rd(5'd2, 5'd31);
        push_exp("pre_reset", 32'h1234, 32'h0, 2'b10, 32'h1234);
        sample();
        reset_i = 1'b1;
        wr0(5'd4, 32'h9);
        bset(5'd4);
        tick();
        reset_i = 1'b0;
        idle();
        push_exp("post_reset_a", 32'h1234 & 32'h0, 32'h0, 2'b00, 32'h0);
        sample();
        set_rd(5'd4, 5'd5);
        push_exp("post_reset_b", 32'h0, 32'h0, 2'b00, 32'h0);
        sample();
        set_rd(5'd9, 5'd31);
        push_exp("post_reset_c", 32'h0, 32'h0, 2'b00, 32'h0);
        sample();

        check_eq("queue_drained", q_exp.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
